// File: rtl/bfloat_pkg.sv
// Shared widths, constants, FSM state type and rounding helper for the bfloat16 datapath.
// Define BF2I_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
package bfloat_pkg;

   localparam int BF_W  = 16;
   localparam int EXP_W = 8;
   localparam int MAN_W = 7;
   localparam int INT_W = 16;
   localparam int CNT_W = 4;

   localparam logic [EXP_W-1:0] EXP_BIAS      = 8'd127;
   localparam logic [EXP_W-1:0] EXP_MAX       = 8'hFF;
   localparam logic [EXP_W-1:0] EXP_MIN_SHIFT = 8'd126;
   // Exponent at which {1,mantissa} is already the integer value.
   localparam logic [EXP_W-1:0] EXP_UNITY     = EXP_BIAS + 8'(MAN_W);
   localparam logic [EXP_W-1:0] EXP_SAT       = EXP_UNITY + 8'd8;

   localparam logic [INT_W-1:0] INT16_MAX    = 16'h7FFF;
   localparam logic [INT_W-1:0] INT16_MIN    = 16'h8000;
   localparam logic [BF_W-1:0]  BF_NEG_32768 = 16'hC700;

`ifdef BF2I_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   function automatic logic [INT_W-1:0] round_and_sign(
      input logic [INT_W-1:0] w,
      input logic             guard,
      input logic             sticky,
      input logic             sign
   );
      logic [INT_W-1:0] mag;
      mag = w + {{(INT_W-1){1'b0}}, ROUND_EN & guard & (sticky | w[0])};
      return sign ? (~mag) + INT_W'(1) : mag;
   endfunction

endpackage

// File: rtl/bfloat_classify.sv
// Combinational bfloat16 operand classifier, shared by the conversion and add/sub paths.
module bfloat_classify
   import bfloat_pkg::*;
(
   input  logic [EXP_W-1:0] exp_i,
   input  logic [MAN_W-1:0] man_i,
   output logic             is_zero,
   output logic             is_sub,
   output logic             is_inf,
   output logic             is_nan,
   output logic             is_norm
);

   logic exp_zero;
   logic exp_max;
   logic man_zero;

   always_comb begin
      exp_zero = (exp_i == '0);
      exp_max  = (exp_i == EXP_MAX);
      man_zero = (man_i == '0);
      is_zero  = exp_zero & man_zero;
      is_sub   = exp_zero & ~man_zero;
      is_inf   = exp_max & man_zero;
      is_nan   = exp_max & ~man_zero;
      is_norm  = ~exp_zero & ~exp_max;
   end

endmodule

// File: rtl/bfloat_to_int.sv
// Multi-cycle bfloat16 -> int16 converter using a 1-bit-per-cycle shifter and valid/ready handshakes.
// Rounding mode is selected by BF2I_ROUND_EN (see bfloat_pkg).
module bfloat_to_int
   import bfloat_pkg::*;
#(
   parameter logic [INT_W-1:0] NAN_VALUE = 16'h8000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BF_W-1:0]   a,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [INT_W-1:0]  c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf,
   output logic              nan,
   output logic              inexact
);

   state_e           state_q, state_d;
   logic [INT_W-1:0] w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             left_q, left_d;
   logic             guard_q, guard_d;
   logic             sticky_q, sticky_d;
   logic             sign_q, sign_d;
   logic [INT_W-1:0] c_q, c_d;
   logic             ovf_q, ovf_d;
   logic             nan_q, nan_d;
   logic             inexact_q, inexact_d;

   logic             a_sign;
   logic [EXP_W-1:0] a_exp;
   logic [MAN_W-1:0] a_man;
   logic             is_zero, is_sub, is_inf, is_nan, is_norm;

   logic [INT_W-1:0] w_shift;
   logic             guard_shift;
   logic             sticky_shift;

   assign a_sign = a[BF_W-1];
   assign a_exp  = a[BF_W-2 -: EXP_W];
   assign a_man  = a[MAN_W-1:0];

   bfloat_classify u_classify (
      .exp_i   (a_exp),
      .man_i   (a_man),
      .is_zero (is_zero),
      .is_sub  (is_sub),
      .is_inf  (is_inf),
      .is_nan  (is_nan),
      .is_norm (is_norm)
   );

   // NOTE: nonblocking assignments here so every flop samples the pre-edge value of its _d.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         w_q       <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         guard_q   <= 1'b0;
         sticky_q  <= 1'b0;
         sign_q    <= 1'b0;
         c_q       <= '0;
         ovf_q     <= 1'b0;
         nan_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         guard_q   <= guard_d;
         sticky_q  <= sticky_d;
         sign_q    <= sign_d;
         c_q       <= c_d;
         ovf_q     <= ovf_d;
         nan_q     <= nan_d;
         inexact_q <= inexact_d;
      end
   end

   // NOTE: every _d starts from its _q so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      guard_d   = guard_q;
      sticky_d  = sticky_q;
      sign_d    = sign_q;
      c_d       = c_q;
      ovf_d     = ovf_q;
      nan_d     = nan_q;
      inexact_d = inexact_q;

      // Right shifts push the old guard into sticky; left shifts lose nothing.
      w_shift      = left_q ? (w_q << 1) : (w_q >> 1);
      guard_shift  = left_q ? guard_q : w_q[0];
      sticky_shift = left_q ? sticky_q : (sticky_q | guard_q);

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sign_d    = a_sign;
               w_d       = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, a_man};
               guard_d   = 1'b0;
               sticky_d  = 1'b0;
               c_d       = '0;
               ovf_d     = 1'b0;
               nan_d     = 1'b0;
               inexact_d = 1'b0;
               state_d   = ST_DONE;
               if (is_nan) begin
                  c_d   = NAN_VALUE;
                  nan_d = 1'b1;
               end else if (is_inf || (is_norm && a_exp >= EXP_SAT)) begin
                  if (a == BF_NEG_32768) begin
                     c_d = INT16_MIN;
                  end else begin
                     c_d   = a_sign ? INT16_MIN : INT16_MAX;
                     ovf_d = 1'b1;
                  end
               end else if (is_zero || is_sub) begin
                  inexact_d = is_sub;
               end else if (a_exp < EXP_MIN_SHIFT) begin
                  inexact_d = 1'b1;
               end else if (a_exp == EXP_UNITY) begin
                  c_d = round_and_sign(w_d, 1'b0, 1'b0, a_sign);
               end else begin
                  state_d = ST_SHIFT;
                  left_d  = (a_exp > EXP_UNITY);
                  cnt_d   = left_d ? CNT_W'(a_exp - EXP_UNITY) : CNT_W'(EXP_UNITY - a_exp);
               end
            end
         end
         ST_SHIFT: begin
            w_d      = w_shift;
            guard_d  = guard_shift;
            sticky_d = sticky_shift;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = ST_DONE;
               c_d       = round_and_sign(w_shift, guard_shift, sticky_shift, sign_q);
               inexact_d = guard_shift | sticky_shift;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      c         = c_q;
      ovf       = ovf_q;
      nan       = nan_q;
      inexact   = inexact_q;
   end

endmodule

// File: tb/tb_bfloat_to_int.sv
// Scoreboard bench for bfloat_to_int: random and directed operands against an arithmetic reference model.
// Honours BF2I_ROUND_EN the same way the design does.
module tb_bfloat_to_int;

`ifdef BF2I_ROUND_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif
   localparam logic [15:0] NAN_V = 16'h5A5A;

   typedef struct {
      logic [15:0] c;
      bit          ovf;
      bit          nan;
      bit          inx;
      bit          chk_inx;
      int          edges;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] c;
   logic        out_valid;
   logic        out_ready;
   logic        ovf;
   logic        nan;
   logic        inexact;

   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   rdy_mode = 0;
   exp_t sb[$];

   bfloat_to_int #(.NAN_VALUE(NAN_V)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf),
      .nan       (nan),
      .inexact   (inexact)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // Reference: value = (128+m) * 2^(e-134), reduced to int16 by integer division.
   function automatic exp_t model(input logic [15:0] av);
      exp_t   r;
      int     ex;
      int     mn;
      bit     s;
      longint n, d, q, rem, mag;
      ex = int'(av[14:7]);
      mn = int'(av[6:0]);
      s  = av[15];
      r.c = 16'h0000; r.ovf = 0; r.nan = 0; r.inx = 0; r.chk_inx = 1; r.edges = 1; r.acc = 0;
      if (ex == 255 && mn != 0) begin
         r.c = NAN_V; r.nan = 1; r.chk_inx = 0;
      end else if (av == 16'hC700) begin
         r.c = 16'h8000;
      end else if (ex >= 142) begin
         r.c = s ? 16'h8000 : 16'h7FFF; r.ovf = 1; r.chk_inx = 0;
      end else if (ex == 0) begin
         r.inx = (mn != 0);
      end else if (ex < 126) begin
         r.inx = 1;
      end else begin
         n = 128 + mn;
         if (ex >= 134) begin
            mag = n * (longint'(1) << (ex - 134));
            r.edges = ex - 134 + 1;
         end else begin
            d   = longint'(1) << (134 - ex);
            q   = n / d;
            rem = n % d;
            r.inx = (rem != 0);
            if (RNE && ((2 * rem > d) || (2 * rem == d && (q % 2) == 1))) q = q + 1;
            mag = q;
            r.edges = 134 - ex + 1;
         end
         r.c = s ? 16'(-mag) : 16'(mag);
      end
      return r;
   endfunction

   task automatic send(input logic [15:0] av, input bit push);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("in_ready_wait", in_ready, in_ready, 1);
      end else begin
         a = av;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (push) begin
            e = model(av);
            e.acc = cyc;
            sb.push_back(e);
         end
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("drain", sb.size() == 0, sb.size(), 0);
   endtask

   // Consumer back-pressure, changed just after the rising edge so it is stable at the negedge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops one expectation per output handshake.
   initial begin
      bit   prev_valid;
      int   vstart;
      exp_t e;
      prev_valid = 0;
      vstart = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 0;
         end else begin
            if (out_valid && !prev_valid) vstart = cyc;
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", sb.size() != 0, c, 0);
               end else begin
                  e = sb.pop_front();
                  check("c", c == e.c, c, e.c);
                  check("ovf", ovf == e.ovf, ovf, e.ovf);
                  check("nan", nan == e.nan, nan, e.nan);
                  if (e.chk_inx) check("inexact", inexact == e.inx, inexact, e.inx);
                  check("latency", (vstart - e.acc + 1) == e.edges, vstart - e.acc + 1, e.edges);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] dir [] = '{16'h3F80, 16'h4060, 16'hC060, 16'h46FF, 16'h4700, 16'hC700,
                              16'hFF80, 16'h7F80, 16'h7FC1, 16'h3F00, 16'h0001, 16'h0000,
                              16'h8000, 16'h4300, 16'h3FC0, 16'h3D00, 16'h4040, 16'hC7FF};
      exp_t e_hold;
      int   t;
      rst = 1'b1;
      a = '0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
      check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
      check("rst_c", c == 16'h0000, c, 0);
      check("rst_flags", {ovf, nan, inexact} == 3'b000, {ovf, nan, inexact}, 0);
      rst = 1'b0;

      foreach (dir[i]) send(dir[i], 1);
      for (int i = 0; i < 250; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if (i % 2 == 0) r[14:7] = 8'($urandom_range(120, 145));
         send(r, 1);
      end
      wait_drain();

      // Back-pressure: result must stay put while the consumer stalls.
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      e_hold = model(16'h4060);
      send(16'h4060, 1);
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_c", c == e_hold.c, c, e_hold.c);
         check("hold_out_valid", out_valid == 1'b1, out_valid, 1);
         check("hold_in_ready", in_ready == 1'b0, in_ready, 0);
      end
      rdy_mode = 0;
      wait_drain();

      // Reset in the middle of a long right shift discards the conversion.
      send(16'h3F00, 0);
      repeat (3) @(negedge clk);
      check("busy_in_ready", in_ready == 1'b0, in_ready, 0);
      check("busy_out_valid", out_valid == 1'b0, out_valid, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_out_valid", out_valid == 1'b0, out_valid, 0);
      check("abort_in_ready", in_ready == 1'b1, in_ready, 1);
      check("abort_c", c == 16'h0000, c, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_output", out_valid == 1'b0, out_valid, 0);

      send(16'h3F80, 1);
      wait_drain();
      check("scoreboard_empty", sb.size() == 0, sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
